// File: rtl/vga_timing_gen.sv
// Pixel timing source: horizontal/vertical counters driving registered DE, HSync, VSync, X, Y.
// Define VGA_TIMING_FRAME_CTR_EN to add the o_FrameStart pulse and the 8-bit o_Frame counter.
`timescale 1ns/1ps
module vga_timing_gen #(
   parameter int unsigned CTR_W      = 10,
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FP       = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BP       = 48,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FP       = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BP       = 33,
   parameter bit          H_SYNC_POL = 1'b0,
   parameter bit          V_SYNC_POL = 1'b0
) (
   input  logic             i_Clk,
   input  logic             i_Rst,
   input  logic             i_En,
   output logic             o_DE,
   output logic             o_HSync,
   output logic             o_VSync,
   output logic [CTR_W-1:0] o_X,
   output logic [CTR_W-1:0] o_Y
`ifdef VGA_TIMING_FRAME_CTR_EN
  ,output logic             o_FrameStart,
   output logic [7:0]       o_Frame
`endif
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned CW      = CTR_W + 1;

   localparam logic [CTR_W-1:0] X_LAST = CTR_W'(H_TOTAL - 1);
   localparam logic [CTR_W-1:0] Y_LAST = CTR_W'(V_TOTAL - 1);

   // Compare constants carry one extra bit so a boundary equal to 2**CTR_W cannot alias to 0
   localparam logic [CTR_W:0] H_ACT_C  = CW'(H_ACTIVE);
   localparam logic [CTR_W:0] HS_BEG_C = CW'(H_ACTIVE + H_FP);
   localparam logic [CTR_W:0] HS_END_C = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CTR_W:0] V_ACT_C  = CW'(V_ACTIVE);
   localparam logic [CTR_W:0] VS_BEG_C = CW'(V_ACTIVE + V_FP);
   localparam logic [CTR_W:0] VS_END_C = CW'(V_ACTIVE + V_FP + V_SYNC);

   logic [CTR_W-1:0] x_q, x_d, y_q, y_d;
   logic [CTR_W:0]   xe, ye;
   logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d;

   // Next pixel position and the outputs describing it, so all outputs line up with X/Y
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (i_En) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + CTR_W'(1);
         end else begin
            x_d = x_q + CTR_W'(1);
         end
      end
      xe   = {1'b0, x_d};
      ye   = {1'b0, y_d};
      de_d = (xe < H_ACT_C) && (ye < V_ACT_C);
      hs_d = ((xe >= HS_BEG_C) && (xe < HS_END_C)) ? H_SYNC_POL : ~H_SYNC_POL;
      vs_d = ((ye >= VS_BEG_C) && (ye < VS_END_C)) ? V_SYNC_POL : ~V_SYNC_POL;
   end

   // Reset parks on the last pixel of a frame so the first enabled edge lands on (0,0)
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         x_q  <= X_LAST;
         y_q  <= Y_LAST;
         de_q <= 1'b0;
         hs_q <= ~H_SYNC_POL;
         vs_q <= ~V_SYNC_POL;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         de_q <= de_d;
         hs_q <= hs_d;
         vs_q <= vs_d;
      end
   end

   assign o_X     = x_q;
   assign o_Y     = y_q;
   assign o_DE    = de_q;
   assign o_HSync = hs_q;
   assign o_VSync = vs_q;

`ifdef VGA_TIMING_FRAME_CTR_EN
   logic       fs_q, fs_d;
   logic [7:0] frame_q, frame_d;

   // Single-cycle pulse on arrival at (0,0); the frame count steps in the same cycle
   always_comb begin
      fs_d    = i_En && (x_d == '0) && (y_d == '0);
      frame_d = fs_d ? frame_q + 8'd1 : frame_q;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         fs_q    <= 1'b0;
         frame_q <= 8'd0;
      end else begin
         fs_q    <= fs_d;
         frame_q <= frame_d;
      end
   end

   assign o_FrameStart = fs_q;
   assign o_Frame      = frame_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default 640x480 instance for line timing and a
// reduced 32x20 instance for frame-scale behaviour (plus a 4x2 instance with the frame counter).
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, en_s, en_b;
   logic s_de, s_hs, s_vs, b_de, b_hs, b_vs;
   logic [9:0] s_x, s_y, b_x, b_y;
`ifdef VGA_TIMING_FRAME_CTR_EN
   logic       s_fs, b_fs, t_fs, t_de, t_hs, t_vs, en_t;
   logic [7:0] s_fr, b_fr, t_fr;
   logic [1:0] t_x, t_y;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int ex, ey;

   // Reduced geometry: H 16/4/6/6 (total 32), V 12/2/3/3 (total 20)
   vga_timing_gen #(
      .CTR_W(10), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3)
   ) u_small (
      .i_Clk(clk), .i_Rst(rst), .i_En(en_s),
      .o_DE(s_de), .o_HSync(s_hs), .o_VSync(s_vs), .o_X(s_x), .o_Y(s_y)
`ifdef VGA_TIMING_FRAME_CTR_EN
     ,.o_FrameStart(s_fs), .o_Frame(s_fr)
`endif
   );

   vga_timing_gen u_big (
      .i_Clk(clk), .i_Rst(rst), .i_En(en_b),
      .o_DE(b_de), .o_HSync(b_hs), .o_VSync(b_vs), .o_X(b_x), .o_Y(b_y)
`ifdef VGA_TIMING_FRAME_CTR_EN
     ,.o_FrameStart(b_fs), .o_Frame(b_fr)
`endif
   );

`ifdef VGA_TIMING_FRAME_CTR_EN
   vga_timing_gen #(
      .CTR_W(2), .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(1), .V_FP(0), .V_SYNC(1), .V_BP(0)
   ) u_tiny (
      .i_Clk(clk), .i_Rst(rst), .i_En(en_t),
      .o_DE(t_de), .o_HSync(t_hs), .o_VSync(t_vs), .o_X(t_x), .o_Y(t_y),
      .o_FrameStart(t_fs), .o_Frame(t_fr)
   );
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model for the reduced instance
   task automatic adv_model();
      if (ex == 31) begin
         ex = 0;
         ey = (ey == 19) ? 0 : ey + 1;
      end else begin
         ex = ex + 1;
      end
   endtask

   function automatic logic exp_de(int x, int y);
      return (x < 16) && (y < 12);
   endfunction
   function automatic logic exp_hs(int x);
      return !((x >= 20) && (x < 26));
   endfunction
   function automatic logic exp_vs(int y);
      return !((y >= 14) && (y < 17));
   endfunction

   task automatic test_reset();
      rst = 1'b1; en_s = 1'b0; en_b = 1'b0;
`ifdef VGA_TIMING_FRAME_CTR_EN
      en_t = 1'b0;
`endif
      #2;
      n_checks += 10;
      if (s_x !== 10'd31)  begin n_fail++; $display("FAIL reset_s_x got %0d want 31", s_x); end
      if (s_y !== 10'd19)  begin n_fail++; $display("FAIL reset_s_y got %0d want 19", s_y); end
      if (s_de !== 1'b0)   begin n_fail++; $display("FAIL reset_s_de got %b want 0", s_de); end
      if (s_hs !== 1'b1)   begin n_fail++; $display("FAIL reset_s_hs got %b want 1", s_hs); end
      if (s_vs !== 1'b1)   begin n_fail++; $display("FAIL reset_s_vs got %b want 1", s_vs); end
      if (b_x !== 10'd799) begin n_fail++; $display("FAIL reset_b_x got %0d want 799", b_x); end
      if (b_y !== 10'd524) begin n_fail++; $display("FAIL reset_b_y got %0d want 524", b_y); end
      if (b_de !== 1'b0)   begin n_fail++; $display("FAIL reset_b_de got %b want 0", b_de); end
      if (b_hs !== 1'b1)   begin n_fail++; $display("FAIL reset_b_hs got %b want 1", b_hs); end
      if (b_vs !== 1'b1)   begin n_fail++; $display("FAIL reset_b_vs got %b want 1", b_vs); end
`ifdef VGA_TIMING_FRAME_CTR_EN
      n_checks += 2;
      if (s_fs !== 1'b0)  begin n_fail++; $display("FAIL reset_fs got %b want 0", s_fs); end
      if (s_fr !== 8'd0)  begin n_fail++; $display("FAIL reset_frame got %0d want 0", s_fr); end
`endif
      tick();
      rst = 1'b0;
      ex = 31; ey = 19;
   endtask

   // Full line 0 of the 640x480 timing, then the first pixel of line 1 and a hold
   task automatic test_line_big();
      int de_cnt = 0;
      int hs_cnt = 0;
      en_b = 1'b1;
      for (int i = 0; i < 800; i++) begin
         tick();
         if (b_de) de_cnt++;
         if (!b_hs) hs_cnt++;
         n_checks += 4;
         if (b_x !== 10'(i)) begin n_fail++; $display("FAIL line_x got %0d want %0d", b_x, i); end
         if (b_y !== 10'd0)  begin n_fail++; $display("FAIL line_y at x=%0d got %0d want 0", i, b_y); end
         if (b_de !== (i < 640)) begin
            n_fail++; $display("FAIL line_de at x=%0d got %b want %b", i, b_de, (i < 640));
         end
         if (b_hs !== !((i >= 656) && (i < 752))) begin
            n_fail++; $display("FAIL line_hs at x=%0d got %b want %b", i, b_hs, !((i >= 656) && (i < 752)));
         end
      end
      n_checks += 2;
      if (de_cnt != 640) begin n_fail++; $display("FAIL line_de_count got %0d want 640", de_cnt); end
      if (hs_cnt != 96)  begin n_fail++; $display("FAIL line_hs_count got %0d want 96", hs_cnt); end
      tick();
      en_b = 1'b0;
      n_checks += 3;
      if (b_x !== 10'd0) begin n_fail++; $display("FAIL line1_x got %0d want 0", b_x); end
      if (b_y !== 10'd1) begin n_fail++; $display("FAIL line1_y got %0d want 1", b_y); end
      if (b_de !== 1'b1) begin n_fail++; $display("FAIL line1_de got %b want 1", b_de); end
      repeat (3) tick();
      n_checks += 2;
      if (b_x !== 10'd0) begin n_fail++; $display("FAIL hold_b_x got %0d want 0", b_x); end
      if (b_y !== 10'd1) begin n_fail++; $display("FAIL hold_b_y got %0d want 1", b_y); end
   endtask

   // Two frames of the reduced timing: every pixel, VSync length/alignment, (0,0) period
   task automatic test_frame();
      int  vs_len = 0;
      int  last_origin = -1;
      logic prev_vs = s_vs;
      en_s = 1'b1;
      for (int i = 1; i <= 1300; i++) begin
         tick();
         adv_model();
         n_checks += 5;
         if (s_x !== 10'(ex)) begin n_fail++; $display("FAIL frame_x got %0d want %0d", s_x, ex); end
         if (s_y !== 10'(ey)) begin n_fail++; $display("FAIL frame_y got %0d want %0d", s_y, ey); end
         if (s_de !== exp_de(ex, ey)) begin
            n_fail++; $display("FAIL frame_de at (%0d,%0d) got %b want %b", ex, ey, s_de, exp_de(ex, ey));
         end
         if (s_hs !== exp_hs(ex)) begin
            n_fail++; $display("FAIL frame_hs at (%0d,%0d) got %b want %b", ex, ey, s_hs, exp_hs(ex));
         end
         if (s_vs !== exp_vs(ey)) begin
            n_fail++; $display("FAIL frame_vs at (%0d,%0d) got %b want %b", ex, ey, s_vs, exp_vs(ey));
         end
         if (s_vs !== prev_vs) begin
            n_checks++;
            if (s_x !== 10'd0) begin n_fail++; $display("FAIL vs_edge_x got %0d want 0", s_x); end
         end
         if (prev_vs === 1'b0 && s_vs === 1'b1) begin
            n_checks++;
            if (vs_len != 96) begin n_fail++; $display("FAIL vs_low_len got %0d want 96", vs_len); end
         end
         vs_len  = (s_vs === 1'b0) ? vs_len + 1 : 0;
         prev_vs = s_vs;
         if (s_x === 10'd0 && s_y === 10'd0) begin
            if (last_origin >= 0) begin
               n_checks++;
               if (i - last_origin != 640) begin
                  n_fail++; $display("FAIL origin_period got %0d want 640", i - last_origin);
               end
            end
            last_origin = i;
         end
      end
      en_s = 1'b0;
   endtask

   // Enable toggling every cycle: outputs advance only on enabled edges
   task automatic test_enable_alt();
      for (int i = 0; i < 200; i++) begin
         en_s = (i % 2 == 0);
         tick();
         if (en_s) adv_model();
         n_checks += 4;
         if (s_x !== 10'(ex)) begin n_fail++; $display("FAIL alt_x step %0d got %0d want %0d", i, s_x, ex); end
         if (s_y !== 10'(ey)) begin n_fail++; $display("FAIL alt_y step %0d got %0d want %0d", i, s_y, ey); end
         if (s_de !== exp_de(ex, ey)) begin n_fail++; $display("FAIL alt_de step %0d got %b", i, s_de); end
         if (s_hs !== exp_hs(ex)) begin n_fail++; $display("FAIL alt_hs step %0d got %b", i, s_hs); end
      end
      en_s = 1'b0;
   endtask

   // Reset asserted while both syncs are active clears everything at once
   task automatic test_mid_reset();
      en_s = 1'b1;
      for (int i = 0; i < 700 && !(ex == 22 && ey == 15); i++) begin
         tick();
         adv_model();
      end
      n_checks += 4;
      if (s_x !== 10'd22) begin n_fail++; $display("FAIL mid_pos_x got %0d want 22", s_x); end
      if (s_y !== 10'd15) begin n_fail++; $display("FAIL mid_pos_y got %0d want 15", s_y); end
      if (s_hs !== 1'b0)  begin n_fail++; $display("FAIL mid_hs got %b want 0", s_hs); end
      if (s_vs !== 1'b0)  begin n_fail++; $display("FAIL mid_vs got %b want 0", s_vs); end
      rst = 1'b1;
      #2;
      n_checks += 5;
      if (s_x !== 10'd31) begin n_fail++; $display("FAIL midrst_x got %0d want 31", s_x); end
      if (s_y !== 10'd19) begin n_fail++; $display("FAIL midrst_y got %0d want 19", s_y); end
      if (s_de !== 1'b0)  begin n_fail++; $display("FAIL midrst_de got %b want 0", s_de); end
      if (s_hs !== 1'b1)  begin n_fail++; $display("FAIL midrst_hs got %b want 1", s_hs); end
      if (s_vs !== 1'b1)  begin n_fail++; $display("FAIL midrst_vs got %b want 1", s_vs); end
      tick();
      n_checks++;
      if (s_x !== 10'd31) begin n_fail++; $display("FAIL rst_held_x got %0d want 31", s_x); end
      rst = 1'b0;
      tick();
      ex = 0; ey = 0;
      n_checks += 3;
      if (s_x !== 10'd0) begin n_fail++; $display("FAIL post_rst_x got %0d want 0", s_x); end
      if (s_y !== 10'd0) begin n_fail++; $display("FAIL post_rst_y got %0d want 0", s_y); end
      if (s_de !== 1'b1) begin n_fail++; $display("FAIL post_rst_de got %b want 1", s_de); end
      en_s = 1'b0;
   endtask

`ifdef VGA_TIMING_FRAME_CTR_EN
   task automatic test_frame_ctr();
      logic [7:0] exp_fr = 8'd0;
      logic [7:0] exp_t  = 8'd0;
      int tx = 3;
      int ty = 1;
      int pulses = 0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ex = 31; ey = 19;
      en_s = 1'b1;
      for (int i = 0; i < 3 * 640; i++) begin
         tick();
         adv_model();
         if (ex == 0 && ey == 0) begin exp_fr = exp_fr + 8'd1; pulses++; end
         n_checks += 2;
         if (s_fs !== (ex == 0 && ey == 0)) begin
            n_fail++; $display("FAIL fs at (%0d,%0d) got %b", ex, ey, s_fs);
         end
         if (s_fr !== exp_fr) begin n_fail++; $display("FAIL frame got %0d want %0d", s_fr, exp_fr); end
      end
      n_checks++;
      if (s_fr !== 8'd3 || pulses != 3) begin
         n_fail++; $display("FAIL frame_final got %0d want 3", s_fr);
      end
      en_s = 1'b0;
      // Tiny instance: 8 cycles per frame, 256 frames to see the 255->0 wrap
      en_t = 1'b1;
      for (int i = 0; i < 256 * 8; i++) begin
         tick();
         if (tx == 3) begin tx = 0; ty = (ty == 1) ? 0 : 1; end else tx = tx + 1;
         if (tx == 0 && ty == 0) exp_t = exp_t + 8'd1;
         n_checks += 2;
         if (t_fs !== (tx == 0 && ty == 0)) begin n_fail++; $display("FAIL tiny_fs got %b", t_fs); end
         if (t_fr !== exp_t) begin n_fail++; $display("FAIL tiny_frame got %0d want %0d", t_fr, exp_t); end
      end
      n_checks++;
      if (t_fr !== 8'd0) begin n_fail++; $display("FAIL tiny_wrap got %0d want 0", t_fr); end
      en_t = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_line_big();
      test_frame();
      test_enable_alt();
      test_mid_reset();
`ifdef VGA_TIMING_FRAME_CTR_EN
      test_frame_ctr();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
